// File: rtl/program_sequencer_if.sv
// Host/datapath bus of the program sequencer: program load, run control,
// the instruction register and its issue/write strobes.
interface program_sequencer_if #(
    parameter int PC_WIDTH = 5
);
    logic                start;
    logic                load_en;
    logic [PC_WIDTH-1:0] load_addr;
    logic [11:0]         load_data;
    logic                zero_flag;
    logic [11:0]         instr;
    logic                issue;
    logic                wr_en;
    logic [PC_WIDTH-1:0] pc;
    logic                busy;
    logic                halted;
    logic [7:0]          retired;

    modport master (
        output start, load_en, load_addr, load_data, zero_flag,
        input  instr, issue, wr_en, pc, busy, halted, retired
    );

    modport slave (
        input  start, load_en, load_addr, load_data, zero_flag,
        output instr, issue, wr_en, pc, busy, halted, retired
    );
endinterface

// File: rtl/program_sequencer.sv
// Three-phase FETCH/EXEC/WB instruction sequencer with a writable program store.
// SKIPIF and HALT are resolved here; ordinary instructions get a WB write strobe.
module program_sequencer #(
    parameter int         PC_WIDTH  = 5,
    parameter logic [3:0] OP_SKIPIF = 4'hD,
    parameter logic [3:0] OP_HALT   = 4'hF
) (
    input logic               inclk,
    input logic               reset,
    program_sequencer_if.slave bus
);
    localparam int DEPTH = 1 << PC_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [11:0]         instr_q, instr_d;
    logic                skip_q, skip_d;
    logic [7:0]          retired_q, retired_d;
    logic                issue_q, issue_d;
    logic                wr_en_q, wr_en_d;
    logic                busy_q, busy_d;
    logic                halted_q, halted_d;

    logic [11:0]         store_mem [DEPTH];
    logic                ctrl_idle;
    logic [3:0]          op;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign ctrl_idle = (state_q == S_IDLE) || (state_q == S_HALTED);
    assign op        = instr_q[11:8];

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        skip_d    = skip_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (bus.start) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            S_FETCH: begin
                instr_d = store_mem[pc_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // HALT retires here; pc keeps pointing at the HALT word.
                if (op == OP_HALT) begin
                    state_d   = S_HALTED;
                    retired_d = sat_inc8(retired_q);
                end else begin
                    state_d = S_WB;
                    skip_d  = (op == OP_SKIPIF) && bus.zero_flag;
                end
            end
            S_WB: begin
                pc_d      = pc_q + (skip_q ? PC_WIDTH'(2) : PC_WIDTH'(1));
                retired_d = sat_inc8(retired_q);
                state_d   = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are registered from the next state so they align with it.
        issue_d  = (state_d == S_EXEC);
        wr_en_d  = (state_d == S_WB) && (instr_d[11:8] != OP_SKIPIF);
        busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_WB);
        halted_d = (state_d == S_HALTED);
    end

    always_ff @(posedge inclk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            skip_q    <= 1'b0;
            retired_q <= '0;
            issue_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            skip_q    <= skip_d;
            retired_q <= retired_d;
            issue_q   <= issue_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    // Program store survives reset; writes only while not running.
    always_ff @(posedge inclk) begin
        if (bus.load_en && ctrl_idle) begin
            store_mem[bus.load_addr] <= bus.load_data;
        end
    end

    assign bus.instr   = instr_q;
    assign bus.issue   = issue_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.pc      = pc_q;
    assign bus.busy    = busy_q;
    assign bus.halted  = halted_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: an instruction-level model expands each run into
// expected per-cycle outputs, checked every cycle, plus hand-computed pins.
module tb_program_sequencer;
    localparam int PW    = 5;
    localparam int DEPTH = 1 << PW;
    localparam logic [3:0] OPS = 4'hD;
    localparam logic [3:0] OPH = 4'hF;

    logic inclk = 1'b0;
    logic reset = 1'b0;

    program_sequencer_if #(.PC_WIDTH(PW)) bus ();

    program_sequencer #(.PC_WIDTH(PW), .OP_SKIPIF(4'hD), .OP_HALT(4'hF)) dut (
        .inclk (inclk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 inclk = ~inclk;

    // Mock datapath: which registers currently read as zero.
    logic [15:0] zf_tbl;
    assign bus.zero_flag = zf_tbl[bus.instr[3:0]];

    typedef struct packed {
        logic          busy;
        logic          issue;
        logic          wr_en;
        logic          halted;
        logic [PW-1:0] pc;
        logic [11:0]   instr;
        logic [7:0]    retired;
    } exp_t;

    exp_t        exp_q[$];
    logic [11:0] m_mem [DEPTH];
    logic [11:0] m_instr;
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;

    task automatic push(input bit b, input bit i, input bit w, input bit h,
                        input int p, input logic [11:0] ir, input int r);
        exp_t e;
        e.busy    = b;
        e.issue   = i;
        e.wr_en   = w;
        e.halted  = h;
        e.pc      = PW'(p);
        e.instr   = ir;
        e.retired = 8'(r);
        exp_q.push_back(e);
    endtask

    // Instruction-level execution from address 0, one record per cycle.
    task automatic model_run(input int ncyc);
        int          p   = 0;
        int          r   = 0;
        int          n   = 0;
        logic [11:0] ir  = m_instr;
        logic [3:0]  op;
        while (n < ncyc) begin
            push(1, 0, 0, 0, p, ir, r); n++;
            ir = m_mem[p];
            op = ir[11:8];
            push(1, 1, 0, 0, p, ir, r); n++;
            if (op == OPH) begin
                r = (r < 255) ? r + 1 : 255;
                while (n < ncyc) begin
                    push(0, 0, 0, 1, p, ir, r); n++;
                end
            end else begin
                push(1, 0, op != OPS, 0, p, ir, r); n++;
                r = (r < 255) ? r + 1 : 255;
                p = (p + ((op == OPS && zf_tbl[ir[3:0]]) ? 2 : 1)) % DEPTH;
            end
        end
        m_instr = ir;
    endtask

    always @(negedge inclk) begin : compare
        exp_t e;
        exp_t a;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.busy    = bus.busy;
            a.issue   = bus.issue;
            a.wr_en   = bus.wr_en;
            a.halted  = bus.halted;
            a.pc      = bus.pc;
            a.instr   = bus.instr;
            a.retired = bus.retired;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL trace cyc=%0d got busy=%b issue=%b wr=%b halt=%b pc=%0d instr=%h ret=%0d want busy=%b issue=%b wr=%b halt=%b pc=%0d instr=%h ret=%0d",
                         cyc, a.busy, a.issue, a.wr_en, a.halted, a.pc, a.instr, a.retired,
                         e.busy, e.issue, e.wr_en, e.halted, e.pc, e.instr, e.retired);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic load_word(input int a, input logic [11:0] d);
        @(posedge inclk); #1;
        bus.load_en   = 1'b1;
        bus.load_addr = PW'(a);
        bus.load_data = d;
        @(posedge inclk); #1;
        bus.load_en   = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic start_run(input int ncyc, input bit do_load, input int a, input logic [11:0] d);
        @(posedge inclk); #1;
        bus.start = 1'b1;
        if (do_load) begin
            bus.load_en   = 1'b1;
            bus.load_addr = PW'(a);
            bus.load_data = d;
        end
        @(posedge inclk); #1;
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        if (do_load) m_mem[a] = d;
        model_run(ncyc);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            @(posedge inclk);
            n++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got=%0d want=0 pending records", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_pc(input int p, input string name);
        bit found = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge inclk); #2;
            if (bus.pc == PW'(p)) begin
                found = 1;
                break;
            end
        end
        chk(name, int'(found), 1);
    endtask

    task automatic run_count(output int wr_cnt);
        wr_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge inclk); #2;
            if (bus.wr_en) wr_cnt++;
            if (bus.halted) break;
        end
    endtask

    task automatic release_reset();
        @(posedge inclk); #1;
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic       s_iss [1:6];
        logic       s_wr  [1:6];
        logic       s_hlt [1:6];
        int         s_pc  [1:6];
        int         s_ret [1:6];
        int         wr_cnt;

        bus.start     = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        zf_tbl        = '0;
        m_instr       = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("rst_pc", int'(bus.pc), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_issue", int'(bus.issue), 0);
        chk("rst_wr", int'(bus.wr_en), 0);
        chk("rst_halted", int'(bus.halted), 0);
        chk("rst_retired", int'(bus.retired), 0);
        chk("rst_instr", int'(bus.instr), 0);
        release_reset();

        // Two-word program: ordinary then HALT
        load_word(0, 12'h123);
        load_word(1, 12'hF00);
        start_run(8, 0, 0, 12'h000);
        for (int i = 1; i <= 6; i++) begin
            #1;
            s_iss[i] = bus.issue;
            s_wr[i]  = bus.wr_en;
            s_hlt[i] = bus.halted;
            s_pc[i]  = int'(bus.pc);
            s_ret[i] = int'(bus.retired);
            @(posedge inclk);
        end
        for (int i = 1; i <= 6; i++) begin
            chk($sformatf("a_issue_t%0d", i + 0), int'(s_iss[i]), (i == 2 || i == 5) ? 1 : 0);
            chk($sformatf("a_wr_t%0d", i + 0), int'(s_wr[i]), (i == 3) ? 1 : 0);
        end
        chk("a_halted_t6", int'(s_hlt[6]), 1);
        chk("a_pc_t6", s_pc[6], 1);
        chk("a_retired_t6", s_ret[6], 2);
        drain("a");

        // SKIPIF at addr 2, taken then not taken
        zf_tbl[5] = 1'b1;
        load_word(0, 12'h100);
        load_word(1, 12'h100);
        load_word(2, 12'hD05);
        load_word(3, 12'h1AA);
        load_word(4, 12'hF00);
        start_run(20, 0, 0, 12'h000);
        run_count(wr_cnt);
        chk("skip1_wr_pulses", wr_cnt, 2);
        drain("skip1");
        chk("skip1_pc", int'(bus.pc), 4);
        chk("skip1_retired", int'(bus.retired), 4);
        zf_tbl[5] = 1'b0;
        start_run(20, 0, 0, 12'h000);
        run_count(wr_cnt);
        chk("skip0_wr_pulses", wr_cnt, 3);
        drain("skip0");
        chk("skip0_pc", int'(bus.pc), 4);
        chk("skip0_retired", int'(bus.retired), 5);

        // SKIPIF at the top address wraps to 1
        zf_tbl[5] = 1'b1;
        load_word(0, 12'hD05);
        load_word(1, 12'hF00);
        for (int a = 2; a < 31; a++) load_word(a, 12'h100);
        load_word(31, 12'hD05);
        start_run(120, 0, 0, 12'h000);
        wait_pc(31, "wrap_skip_reach31");
        repeat (3) @(posedge inclk);
        #2;
        chk("wrap_skip_pc", int'(bus.pc), 1);
        drain("wrap_skip");
        chk("wrap_skip_halted", int'(bus.halted), 1);
        chk("wrap_skip_retired", int'(bus.retired), 32);

        // Endless loop: ordinary at 31 wraps to 0; busy-time load/start ignored
        load_word(31, 12'h100);
        start_run(950, 0, 0, 12'h000);
        repeat (10) @(posedge inclk);
        #1;
        bus.load_en   = 1'b1;
        bus.load_addr = PW'(5);
        bus.load_data = 12'hABC;
        @(posedge inclk); #1;
        bus.load_en   = 1'b0;
        repeat (3) @(posedge inclk);
        #1;
        bus.start = 1'b1;
        @(posedge inclk); #1;
        bus.start = 1'b0;
        wait_pc(31, "wrap_ord_reach31");
        repeat (3) @(posedge inclk);
        #2;
        chk("wrap_ord_pc", int'(bus.pc), 0);
        drain("loop");
        chk("loop_retired_sat", int'(bus.retired), 255);

        // Asynchronous reset in FETCH at pc 7
        wait_pc(7, "rst_reach7");
        chk("pre_rst_fetch", int'(bus.busy && !bus.issue && !bus.wr_en), 1);
        exp_q.delete();
        reset   = 1'b1;
        m_instr = '0;
        #1;
        chk("mid_rst_pc", int'(bus.pc), 0);
        chk("mid_rst_busy", int'(bus.busy), 0);
        chk("mid_rst_issue", int'(bus.issue), 0);
        chk("mid_rst_wr", int'(bus.wr_en), 0);
        chk("mid_rst_retired", int'(bus.retired), 0);
        release_reset();

        // Store survives reset (addr 5 still ordinary)
        start_run(30, 0, 0, 12'h000);
        drain("reread");
        exp_q.delete();
        reset   = 1'b1;
        m_instr = '0;
        release_reset();

        // start with load in IDLE, then start with load in HALTED
        start_run(12, 1, 0, 12'h100);
        drain("idle_load");
        chk("idle_load_halted", int'(bus.halted), 1);
        chk("idle_load_pc", int'(bus.pc), 1);
        chk("idle_load_retired", int'(bus.retired), 2);
        start_run(6, 1, 0, 12'hF0A);
        #1;
        @(posedge inclk); #1;
        chk("halt_load_instr", int'(bus.instr), 12'hF0A);
        chk("halt_load_retired", int'(bus.retired), 0);
        chk("halt_load_issue", int'(bus.issue), 1);
        drain("halt_load");
        chk("halt_load_pc_end", int'(bus.pc), 0);
        chk("halt_load_ret_end", int'(bus.retired), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
